// File: rtl/dac_scaler_pkg.sv
// Shared definitions for the DAC code scaler.
//   MODE_W      width of each channel's mode field in the mode bus
//   MODE_SCALED mode value that selects gain/offset scaling
//   state_t     conversion sequencer states
package dac_scaler_pkg;

  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_SCALED = 3'b001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FLUSH  = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/dac_code_clamp.sv
// Converts one signed channel value y into an unsigned DAC code.
//   k = 2^(OUT_W-1) - y at full width, saturated to [0, 2^OUT_W-1],
//   then optionally bit-inverted.
// Ports:
//   y     in   YW      signed channel value (scaled or bypassed sample)
//   inv   in   1       bit-invert the final code
//   k     out  OUT_W   DAC code
//   clip  out  1       saturation limited the code
module dac_code_clamp #(
  parameter int YW    = 34,
  parameter int OUT_W = 12
) (
  input  logic signed [YW-1:0] y,
  input  logic                 inv,
  output logic [OUT_W-1:0]     k,
  output logic                 clip
);

  // One extra bit so that MID - y can never wrap.
  localparam int KW = YW + 1;
  localparam logic signed [KW-1:0] MID  = KW'(2 ** (OUT_W - 1));
  localparam logic signed [KW-1:0] MAXC = KW'(2 ** OUT_W - 1);

  logic signed [KW-1:0] k_full;
  logic [OUT_W-1:0]     k_sat;

  // Full-width code, saturation and optional inversion.
  always_comb begin
    k_full = MID - KW'(y);
    k_sat  = k_full[OUT_W-1:0];
    clip   = 1'b0;
    if (k_full[KW-1]) begin
      k_sat = '0;
      clip  = 1'b1;
    end else if (k_full > MAXC) begin
      k_sat = '1;
      clip  = 1'b1;
    end else begin
      k_sat = k_full[OUT_W-1:0];
      clip  = 1'b0;
    end
    if (inv) begin
      k = ~k_sat;
    end else begin
      k = k_sat;
    end
  end

endmodule

// File: rtl/dac_code_scaler.sv
// N-channel amplitude/offset scaler and signed-to-DAC-code converter.
// A single multiplier is shared across channels: on en the inputs are
// captured into shadow registers, each channel is multiplied in turn, the
// registered product is offset/clamped into a staging register, and all
// channels are committed to dout together with a one-cycle dout_valid.
// Optional feature macro: DAC_CLIP_FLAG_EN adds the sticky clip_flag port.
// Ports:
//   clk        in   1           system clock
//   reset      in   1           asynchronous active-high reset
//   en         in   1           sample strobe (ignored and flagged while busy)
//   run        in   32          bit c = channel c run enable
//   mode       in   32          bits [3c+2:3c] = channel c mode
//   amp        in   NCH*AMP_W   unsigned Q-format amplitudes
//   off        in   NCH*IN_W    signed offsets
//   din        in   NCH*IN_W    signed samples
//   ovr_clr    in   1           clears overrun (and clip_flag)
//   dout       out  NCH*OUT_W   DAC codes
//   dout_valid out  1           one-cycle pulse when dout updates
//   busy       out  1           conversion in progress
//   overrun    out  1           sticky: en arrived while busy
//   clip_flag  out  NCH         (DAC_CLIP_FLAG_EN only) sticky per-channel clip
module dac_code_scaler
  import dac_scaler_pkg::*;
#(
  parameter int             NCH      = 2,
  parameter int             IN_W     = 16,
  parameter int             AMP_W    = 16,
  parameter int             AMP_FRAC = 14,
  parameter int             OUT_W    = 12,
  parameter logic [NCH-1:0] INV_MASK = 2'b10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [31:0]          run,
  input  logic [31:0]          mode,
  input  logic [NCH*AMP_W-1:0] amp,
  input  logic [NCH*IN_W-1:0]  off,
  input  logic [NCH*IN_W-1:0]  din,
  input  logic                 ovr_clr,
  output logic [NCH*OUT_W-1:0] dout,
  output logic                 dout_valid,
  output logic                 busy,
`ifdef DAC_CLIP_FLAG_EN
  output logic                 overrun,
  output logic [NCH-1:0]       clip_flag
`else
  output logic                 overrun
`endif
);

  localparam int PW    = IN_W + AMP_W + 1;
  localparam int YW    = PW + 1;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [OUT_W-1:0] MID_CODE = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic [NCH*OUT_W-1:0] reset_dout();
    logic [NCH*OUT_W-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      r[c*OUT_W +: OUT_W] = INV_MASK[c] ? ~MID_CODE : MID_CODE;
    end
    return r;
  endfunction

  localparam logic [NCH*OUT_W-1:0] DOUT_RST = reset_dout();

  state_t state;
  state_t state_nx;

  logic [IDX_W-1:0]       idx;
  logic [NCH*IN_W-1:0]    din_sh;
  logic [NCH*IN_W-1:0]    off_sh;
  logic [NCH*AMP_W-1:0]   amp_sh;
  logic [NCH-1:0]         scaled_sh;

  logic signed [PW-1:0]   prod;
  logic                   prod_vld;
  logic [IDX_W-1:0]       prod_ch;
  logic [NCH*OUT_W-1:0]   stage;

  logic signed [IN_W-1:0] din_sel;
  logic [AMP_W-1:0]       amp_sel;
  logic signed [PW-1:0]   mult;

  logic signed [IN_W-1:0] pdin;
  logic signed [IN_W-1:0] poff;
  logic                   pscaled;
  logic signed [PW-1:0]   prod_shift;
  logic signed [YW-1:0]   y;
  logic [OUT_W-1:0]       code;
  logic                   clip;
  logic                   accept;
  logic                   drop;

  // Only the low bits of run/mode are meaningful for NCH channels.
  logic unused_ctrl;
  assign unused_ctrl = ^{run, mode};

  assign accept = en && (state == IDLE);
  assign drop   = en && (state != IDLE);

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        if (idx == IDX_W'(NCH - 1)) begin
          state_nx = FLUSH;
        end else begin
          state_nx = CALC;
        end
      end
      FLUSH:   state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared multiplier: channel idx sample times zero-extended amplitude.
  always_comb begin
    din_sel = din_sh[idx*IN_W +: IN_W];
    amp_sel = amp_sh[idx*AMP_W +: AMP_W];
    mult    = PW'(din_sel) * PW'($signed({1'b0, amp_sel}));
  end

  // Offset add (or bypass) for the channel whose product is registered.
  always_comb begin
    pdin       = din_sh[prod_ch*IN_W +: IN_W];
    poff       = off_sh[prod_ch*IN_W +: IN_W];
    pscaled    = scaled_sh[prod_ch];
    prod_shift = prod >>> AMP_FRAC;
    if (pscaled) begin
      y = YW'(prod_shift) + YW'(poff);
    end else begin
      y = YW'(pdin);
    end
  end

  dac_code_clamp #(
    .YW    (YW),
    .OUT_W (OUT_W)
  ) u_clamp (
    .y    (y),
    .inv  (INV_MASK[prod_ch]),
    .k    (code),
    .clip (clip)
  );

  // Input capture into shadow registers; scaling decision is folded in here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_sh    <= '0;
      off_sh    <= '0;
      amp_sh    <= '0;
      scaled_sh <= '0;
    end else if (accept) begin
      din_sh <= din;
      off_sh <= off;
      amp_sh <= amp;
      for (int c = 0; c < NCH; c++) begin
        scaled_sh[c] <= (mode[c*MODE_W +: MODE_W] == MODE_SCALED) && run[c];
      end
    end
  end

  // Channel index and product pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      prod_ch  <= '0;
    end else begin
      if (accept) begin
        idx <= '0;
      end else if (state == CALC) begin
        idx <= idx + IDX_W'(1);
      end
      prod_vld <= (state == CALC);
      if (state == CALC) begin
        prod    <= mult;
        prod_ch <= idx;
      end
    end
  end

  // Staging register collects clamped codes until all channels are ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= DOUT_RST;
    end else if (prod_vld) begin
      stage[prod_ch*OUT_W +: OUT_W] <= code;
    end
  end

  // Output register, valid strobe and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= DOUT_RST;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= (state == COMMIT);
      busy       <= (state_nx != IDLE);
      if (state == COMMIT) begin
        dout <= stage;
      end
    end
  end

  // Sticky overrun: a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef DAC_CLIP_FLAG_EN
  // Sticky per-channel clip flags; a new clip outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_flag <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (prod_vld && clip && (prod_ch == IDX_W'(c))) begin
          clip_flag[c] <= 1'b1;
        end else if (ovr_clr) begin
          clip_flag[c] <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_clip;
  assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_dac_code_scaler.sv
// Self-checking bench for dac_code_scaler (NCH=2, default parameters).
// A transaction-level model predicts dout/dout_valid/busy/overrun each
// cycle; directed scenarios add hand-computed literal expectations.
module tb_dac_code_scaler;

  localparam int NCH = 2;
  localparam logic [1:0] INV = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [31:0] run = '0;
  logic [31:0] mode = '0;
  logic [31:0] amp = '0;
  logic [31:0] off = '0;
  logic [31:0] din = '0;
  logic        ovr_clr = 1'b0;
  logic [23:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        overrun;
`ifdef DAC_CLIP_FLAG_EN
  logic [1:0]  clip_flag;
`endif

  int checks = 0;
  int errors = 0;

  dac_code_scaler dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .run        (run),
    .mode       (mode),
    .amp        (amp),
    .off        (off),
    .din        (din),
    .ovr_clr    (ovr_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
`ifdef DAC_CLIP_FLAG_EN
    .overrun    (overrun),
    .clip_flag  (clip_flag)
`else
    .overrun    (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected DAC code for one channel straight from the conversion rules.
  function automatic longint exp_code(input int c, input logic [15:0] d, input logic [15:0] o,
                                      input logic [15:0] a, input logic [2:0] md, input logic rn);
    longint dv, ov, av, p, y, k;
    dv = longint'($signed(d));
    ov = longint'($signed(o));
    av = longint'(a);
    if (md == 3'd1 && rn) begin
      p = dv * av;
      if (p >= 0) y = p / 16384;
      else        y = -((-p + 16383) / 16384);
      y = y + ov;
    end else begin
      y = dv;
    end
    k = 2048 - y;
    if (k < 0) k = 0;
    if (k > 4095) k = 4095;
    if (INV[c]) k = 4095 - k;
    return k;
  endfunction

  // Behavioural model: a conversion takes NCH+2 edges, en during that time is dropped.
  longint m_dout0, m_dout1, m_pend0, m_pend1;
  logic   m_valid, m_ovr;
  int     m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dout0 = 2048; m_dout1 = 2047;
      m_valid = 1'b0; m_ovr = 1'b0; m_cnt = 0;
    end else begin
      logic dropped;
      dropped = 1'b0;
      m_valid = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_dout0 = m_pend0; m_dout1 = m_pend1; m_valid = 1'b1;
        end
        if (en) dropped = 1'b1;
      end else if (en) begin
        m_pend0 = exp_code(0, din[15:0], off[15:0], amp[15:0], mode[2:0], run[0]);
        m_pend1 = exp_code(1, din[31:16], off[31:16], amp[31:16], mode[5:3], run[1]);
        m_cnt = NCH + 2;
      end
      if (dropped) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("dout0", longint'(dout[11:0]), m_dout0);
    check("dout1", longint'(dout[23:12]), m_dout1);
    check("dout_valid", longint'(dout_valid), longint'(m_valid));
    check("busy", longint'(busy), longint'(m_cnt > 0));
    check("overrun", longint'(overrun), longint'(m_ovr));
  end

  // Waits for idle, pulses en with the given inputs, waits for dout_valid.
  task automatic do_conv(input int d0, input int d1, input int o0, input int o1,
                         input int a0, input int a1, input logic [31:0] md,
                         input logic [31:0] rn, output int lat);
    int n;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    check("idle_before_en", longint'(busy), 0);
    din = {d1[15:0], d0[15:0]};
    off = {o1[15:0], o0[15:0]};
    amp = {a1[15:0], a0[15:0]};
    mode = md; run = rn;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    lat = 0;
    while (!dout_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("valid_seen", longint'(dout_valid), 1);
  endtask

  initial begin
    int lat;
    logic [31:0] rmode;
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rmode;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_dout", longint'(dout), longint'({12'd2047, 12'd2048}));
    check("rst_flags", longint'({dout_valid, busy, overrun}), 0);

    // Bypass with inversion on channel 1, plus latency.
    do_conv(100, -100, 0, 0, 0, 0, 32'h0, 32'h0, lat);
    check("t1_dout0", longint'(dout[11:0]), 1948);
    check("t1_dout1", longint'(dout[23:12]), 1947);
    check("t1_latency", longint'(lat), 4);
    @(posedge clk); #1;
    check("t1_single_pulse", longint'(dout_valid), 0);

    // Scaled half gain with offset, then the same with run cleared.
    do_conv(1000, 0, 10, 0, 32'h2000, 0, 32'h1, 32'h1, lat);
    check("t2_scaled", longint'(dout[11:0]), 1538);
    check("t2_ch1", longint'(dout[23:12]), 2047);
    do_conv(1000, 0, 10, 0, 32'h2000, 0, 32'h1, 32'h0, lat);
    check("t2_run_off", longint'(dout[11:0]), 1048);

    // Saturation both ways at unity gain.
    do_conv(3000, 0, 0, 0, 32'h4000, 0, 32'h1, 32'h1, lat);
    check("t3_sat_low", longint'(dout[11:0]), 0);
    do_conv(-3000, 0, 0, 0, 32'h4000, 0, 32'h1, 32'h1, lat);
    check("t3_sat_high", longint'(dout[11:0]), 4095);
`ifdef DAC_CLIP_FLAG_EN
    check("t3_clip", longint'(clip_flag[0]), 1);
`endif

    // Floor rounding of a negative product.
    do_conv(-1, 0, 0, 0, 32'h2000, 0, 32'h1, 32'h1, lat);
    check("t4_floor", longint'(dout[11:0]), 2049);

    // Overrun: en held two cycles, second one dropped.
    din = {16'd0, 16'd100}; off = '0; amp = '0; mode = '0; run = '0;
    en = 1'b1;
    @(posedge clk); #1;
    din = {16'd0, 16'd500};
    @(posedge clk); #1;
    en = 1'b0;
    lat = 0;
    while (!dout_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("t5_dout0", longint'(dout[11:0]), 1948);
    check("t5_overrun", longint'(overrun), 1);
    en = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; ovr_clr = 1'b0;
    check("t5_set_wins", longint'(overrun), 1);
    repeat (6) @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    check("t5_cleared", longint'(overrun), 0);

    // Reset in the middle of a conversion.
    din = {16'd7, 16'd900}; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t6_dout", longint'(dout), longint'({12'd2047, 12'd2048}));
    check("t6_busy", longint'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_conv(200, 300, 0, 0, 0, 0, 32'h0, 32'h0, lat);
    check("t6_after0", longint'(dout[11:0]), 1848);
    check("t6_after1", longint'(dout[23:12]), 4095 - 1748);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      en = ($urandom_range(0, 2) == 0);
      ovr_clr = ($urandom_range(0, 15) == 0);
      din = $urandom;
      off = $urandom;
      amp = $urandom;
      rmode = $urandom;
      if ($urandom_range(0, 1) == 1) rmode[2:0] = 3'b001;
      if ($urandom_range(0, 1) == 1) rmode[5:3] = 3'b001;
      mode = rmode;
      run = $urandom;
    end
    en = 1'b0; ovr_clr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
